alu_arbiter_seq: RTL and testbench

//  Shares the single 4-bit ALU (A, B, ALU_operation, ALU_enable, tri-state

---
 rtl/alu_arbiter_seq.sv | 131 +++++++++++++
 tb/tb_alu_arbiter_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: shares one WIDTH-bit ALU between two requesters (IDLE -> DRIVE -> DONE).
// Ties are round-robin by default; define ALU_ARB_FIXED_PRIO_EN to always favour requester 0.
module alu_arbiter_seq #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             carry_q,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_operation,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_bus,
    input  logic             alu_carry
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             op_q, op_d, carry_cap_q, carry_cap_d;
    logic             win;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win = req1 & ~req0;
`else
    logic last_q, last_d;

    // On a tie the requester that was not served last wins.
    assign win = req1 & (~req0 | ~last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == DONE) last_d = grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        carry_cap_d = carry_cap_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    grant_d = win;
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    op_d    = win ? op1 : op0;
                    cnt_d   = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // Bus is sampled on the edge that closes the settle window.
                if (cnt_q == CNT_LAST) begin
                    res_d       = alu_bus;
                    carry_cap_d = alu_carry;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            res_q       <= '0;
            carry_cap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            carry_cap_q <= carry_cap_d;
        end
    end

    // Enable is decoded from DRIVE alone so the shared bus is never driven elsewhere.
    assign alu_enable    = (state_q == DRIVE);
    assign busy          = (state_q != IDLE);
    assign ack0          = (state_q == DONE) & ~grant_q;
    assign ack1          = (state_q == DONE) &  grant_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_operation = op_q;
    assign result        = res_q;
    assign carry_q       = carry_cap_q;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed bench for alu_arbiter_seq with a behavioural ALU (op 0 = add, op 1 = subtract/borrow)
// and a scoreboard of expected grant/result/carry popped on every ack.
`timescale 1ns/1ps
module tb_alu_arbiter_seq;
    localparam int W = 4;
    typedef struct packed { logic g; logic [W-1:0] r; logic c; } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic req0, req1, op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic ack0, ack1, carry_q, busy, alu_operation, alu_enable, alu_carry;
    logic [W-1:0] result, alu_a, alu_b, alu_bus;

    logic r3;
    logic [W-1:0] a3, b3;
    logic d3_ack0, d3_ack1, d3_carry, d3_busy, d3_op, d3_en, d3_alu_carry;
    logic [W-1:0] d3_result, d3_a, d3_b, d3_bus;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter_seq #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0), .ack1(ack1),
        .result(result), .carry_q(carry_q), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
        .alu_operation(alu_operation), .alu_enable(alu_enable),
        .alu_bus(alu_bus), .alu_carry(alu_carry)
    );

    alu_arbiter_seq #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req0(r3), .req1(1'b0), .op0(1'b0), .op1(1'b0),
        .a0(a3), .b0(b3), .a1(4'h0), .b1(4'h0), .ack0(d3_ack0), .ack1(d3_ack1),
        .result(d3_result), .carry_q(d3_carry), .busy(d3_busy), .alu_a(d3_a), .alu_b(d3_b),
        .alu_operation(d3_op), .alu_enable(d3_en),
        .alu_bus(d3_bus), .alu_carry(d3_alu_carry)
    );

    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        logic [W:0] ea, eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return op ? (ea - eb) : (ea + eb);
    endfunction

    // Off-bus value is deliberately non-zero so a mistimed capture shows up.
    always_comb begin
        if (alu_enable) {alu_carry, alu_bus} = alu_f(alu_a, alu_b, alu_operation);
        else            {alu_carry, alu_bus} = 5'h1A;
        if (d3_en) {d3_alu_carry, d3_bus} = alu_f(d3_a, d3_b, d3_op);
        else       {d3_alu_carry, d3_bus} = 5'h1A;
    end

    function automatic exp_t mk(input logic g, input logic [W-1:0] r, input logic c);
        exp_t e;
        e.g = g;
        e.r = r;
        e.c = c;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int max, output int lat, output int en);
        lat = 0;
        en  = 0;
        do begin
            step(1);
            lat++;
            if (alu_enable) en++;
        end while (!(ack0 || ack1) && lat < max);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input exp_t e);
        int lat, en;
        req0 = 1'b1; a0 = a; b0 = b; op0 = op;
        sb.push_back(e);
        wait_ack(10, lat, en);
        chk({tag, "_ack0"}, ack0, 1);
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_enable_cycles"}, en, 1);
        req0 = 1'b0;
        step(1);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (ack0 || ack1) begin
            chk("ack_exclusive", {31'd0, ack0 & ack1}, 0);
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL unexpected_ack: observed ack0=%0b ack1=%0b expected none", ack0, ack1);
            end else begin
                e = sb.pop_front();
                chk("sb_grant", ack1, e.g);
                chk("sb_result", result, e.r);
                chk("sb_carry", carry_q, e.c);
            end
        end
        if (alu_enable) chk("enable_implies_busy", busy, 1);
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, en, n;
        rst = 1'b1; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; r3 = 0; a3 = '0; b3 = '0;

        // 1: reset state
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_enable", alu_enable, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry_q, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_operation, 0);
        chk("rst_d3_busy", d3_busy, 0);
        rst = 1'b0;
        step(1);

        // 2-3: single requester, add / overflow / subtract
        run_op("add_3_5", 4'h3, 4'h5, 1'b0, mk(1'b0, 4'h8, 1'b0));
        run_op("add_F_1", 4'hF, 4'h1, 1'b0, mk(1'b0, 4'h0, 1'b1));
        run_op("sub_7_3", 4'h7, 4'h3, 1'b1, mk(1'b0, 4'h4, 1'b0));

        // 4: both requesters held for four operations, from a fresh reset
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req0 = 1; a0 = 4'h1; b0 = 4'h1; op0 = 0;
        req1 = 1; a1 = 4'h6; b1 = 4'h2; op1 = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            sb.push_back(mk(1'b0, 4'h2, 1'b0));
`else
            if (i % 2 == 0) sb.push_back(mk(1'b0, 4'h2, 1'b0));
            else            sb.push_back(mk(1'b1, 4'h4, 1'b0));
`endif
        end
        n = 0;
        lat = 0;
        while (n < 4 && lat < 40) begin
            step(1);
            lat++;
            if (ack0 || ack1) n++;
        end
        chk("arb_ack_count", n, 4);
        req0 = 0; req1 = 0;
        step(1);
        chk("arb_queue_drained", sb.size(), 0);

        // 5: reset while the ALU is enabled aborts the operation
        req0 = 1; a0 = 4'h1; b0 = 4'h1; op0 = 0;
        step(1);
        chk("abort_in_drive", alu_enable, 1);
        rst = 1'b1; req0 = 0;
        step(1);
        chk("abort_busy", busy, 0);
        chk("abort_enable", alu_enable, 0);
        chk("abort_ack0", ack0, 0);
        chk("abort_result", result, 0);
        chk("abort_carry", carry_q, 0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (ack0 || ack1) n++;
        end
        chk("abort_no_ack", n, 0);

        // 6: operands changed and request dropped after grant
        req0 = 1; a0 = 4'h2; b0 = 4'h4; op0 = 0;
        sb.push_back(mk(1'b0, 4'h6, 1'b0));
        step(1);
        chk("late_granted", alu_enable, 1);
        a0 = 4'h9; req0 = 0;
        wait_ack(10, lat, en);
        chk("late_ack0", ack0, 1);
        chk("late_latency", lat, 1);
        chk("late_alu_a_latched", alu_a, 4'h2);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (ack0 || ack1) n++;
        end
        chk("late_single_ack", n, 0);

        // 6: longer settle window on the SETTLE_CYCLES=3 instance
        r3 = 1; a3 = 4'h5; b3 = 4'h6;
        lat = 0; en = 0;
        do begin
            step(1);
            lat++;
            if (d3_en) en++;
        end while (!d3_ack0 && lat < 12);
        chk("s3_ack0", d3_ack0, 1);
        chk("s3_latency", lat, 4);
        chk("s3_enable_cycles", en, 3);
        chk("s3_result", d3_result, 4'hB);
        chk("s3_carry", d3_carry, 0);
        r3 = 0;
        step(2);
        chk("s3_idle", d3_busy, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
